// File: rtl/game_pkg.sv
// Shared definitions for the dino game blocks: random word width,
// obstacle type encodings and the obstacle scheduler state machine.
package game_pkg;

   localparam int RAND_W = 9;

   typedef enum logic [1:0] {
      OBS_SMALL = 2'b00,
      OBS_LARGE = 2'b01,
      OBS_GROUP = 2'b10,
      OBS_BIRD  = 2'b11
   } obs_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_COUNT = 2'd2,
      ST_SPAWN = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rand_fifo.sv
// Small synchronous FIFO that prefetches random words. The push side is a
// valid/ready handshake; the read side exposes the head word, empty and level.
// A word written in one cycle becomes visible at the head the next cycle.
module rand_fifo
   import game_pkg::*;
#(
   parameter int W     = RAND_W,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   input  logic [W-1:0]     push_data,
   output logic             push_ready,
   input  logic             pop,
   output logic [W-1:0]     pop_data,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             do_pop;

   // Ready comes only from the registered level, so a same-cycle pop never
   // opens a slot for a push while full.
   assign push_ready = (level != FULL_LVL);
   assign empty      = (level == '0);
   assign push       = push_valid && push_ready;
   assign do_pop     = pop && !empty;
   assign pop_data   = mem[rd_ptr];

   // Storage array; data needs no reset because level gates its use.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at DEPTH; level tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Consumes random words, turns each into an obstacle type and a spawn gap,
// counts the gap down by scroll speed on frame ticks and pulses spawn.
module obstacle_scheduler
   import game_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_MIN    = 96,
   parameter int GAP_W      = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rand_valid,
   input  logic [RAND_W-1:0]           rand_data,
   output logic                        rand_ready,
   input  logic                        run,
   input  logic                        tick,
   input  logic [2:0]                  speed,
   output logic                        spawn,
   output logic [1:0]                  spawn_type,
   output logic [7:0]                  spawn_count,
   output logic                        starved,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam logic [GAP_W-1:0] GAP_MIN_V = GAP_W'(GAP_MIN);

   sched_state_t      state;
   logic [GAP_W-1:0]  gap_cnt;
   obs_t              type_nxt;
   logic [RAND_W-1:0] head;
   logic              empty;
   logic              pop;
   logic [GAP_W-1:0]  speed_ext;
   logic [GAP_W-1:0]  gap_new;

   rand_fifo #(
      .W     (RAND_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (rand_valid),
      .push_data  (rand_data),
      .push_ready (rand_ready),
      .pop        (pop),
      .pop_data   (head),
      .empty      (empty),
      .level      (fifo_level)
   );

   assign speed_ext = GAP_W'(speed);
   // Low bits of the word give an even gap offset (0..254) above the minimum.
   assign gap_new   = GAP_MIN_V + GAP_W'({head[RAND_W-3:0], 1'b0});
   // Only a running LOAD consumes a word; a pause leaves the FIFO intact.
   assign pop       = (state == ST_LOAD) && run && !empty;
   assign starved   = (state == ST_LOAD) && empty;

   // Scheduler FSM with registered spawn outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         gap_cnt     <= '0;
         type_nxt    <= OBS_SMALL;
         spawn       <= 1'b0;
         spawn_type  <= OBS_SMALL;
         spawn_count <= '0;
      end else begin
         spawn <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (!run) begin
                  state   <= ST_IDLE;
                  gap_cnt <= '0;
               end else if (!empty) begin
                  gap_cnt  <= gap_new;
                  type_nxt <= obs_t'(head[RAND_W-1 -: 2]);
                  state    <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (!run) begin
                  // Pausing cancels the pending spawn and discards the gap.
                  state   <= ST_IDLE;
                  gap_cnt <= '0;
               end else if (tick && (speed_ext != '0)) begin
                  if (gap_cnt <= speed_ext) begin
                     // Type and count update with the pulse so the renderer
                     // sees them in the same cycle as spawn.
                     state       <= ST_SPAWN;
                     spawn       <= 1'b1;
                     spawn_type  <= type_nxt;
                     spawn_count <= spawn_count + 8'd1;
                  end else begin
                     gap_cnt <= gap_cnt - speed_ext;
                  end
               end
            end
            ST_SPAWN: begin
               if (run) begin
                  state <= ST_LOAD;
               end else begin
                  state   <= ST_IDLE;
                  gap_cnt <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: directed phases with a spawn scoreboard.
module tb_obstacle_scheduler;
   import game_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       rand_valid;
   logic [8:0] rand_data;
   logic       rand_ready;
   logic       run;
   logic       tick;
   logic [2:0] speed;
   logic       spawn;
   logic [1:0] spawn_type;
   logic [7:0] spawn_count;
   logic       starved;
   logic [2:0] fifo_level;

   typedef struct packed {
      logic [1:0] t;
      logic [7:0] c;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_cnt;
   int         n_vec;
   int         n_err;

   obstacle_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rand_valid  (rand_valid),
      .rand_data   (rand_data),
      .rand_ready  (rand_ready),
      .run         (run),
      .tick        (tick),
      .speed       (speed),
      .spawn       (spawn),
      .spawn_type  (spawn_type),
      .spawn_count (spawn_count),
      .starved     (starved),
      .fifo_level  (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_spawn(input logic [1:0] t);
      exp_cnt = exp_cnt + 8'd1;
      sb.push_back('{t: t, c: exp_cnt});
   endtask

   // Pulse tick every other cycle until spawn shows; returns ticks used.
   task automatic run_until_spawn(input int max, output int n);
      bit got;
      n = 0;
      got = 0;
      while (!got && n < max) begin
         tick = 1'b1;
         step();
         n++;
         if (spawn) got = 1;
         tick = 1'b0;
         step();
      end
      if (!got) chk("spawn_timeout", 0, 1);
   endtask

   // Scoreboard: every spawn pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && spawn) begin
         if (sb.size() == 0) begin
            chk("spawn_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("spawn_type", 32'(spawn_type), 32'(e.t));
            chk("spawn_count", 32'(spawn_count), 32'(e.c));
         end
      end
   end

   initial begin
      int n;
      int cnt;
      logic [8:0] words [4];
      words[0] = 9'h183;
      words[1] = 9'h00D;
      words[2] = 9'h100;
      words[3] = 9'h07F;
      n_vec = 0;
      n_err = 0;
      exp_cnt = 8'd0;
      rand_valid = 1'b0;
      rand_data = '0;
      run = 1'b0;
      tick = 1'b0;
      speed = 3'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_ready", 32'(rand_ready), 1);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_spawn", 32'(spawn), 0);
      chk("rst_type", 32'(spawn_type), 0);
      chk("rst_count", 32'(spawn_count), 0);
      chk("rst_starved", 32'(starved), 0);
      step();
      rst_n = 1'b1;
      step();

      // Prefetch four words while paused, then offer a fifth.
      for (int i = 0; i < 4; i++) begin
         rand_valid = 1'b1;
         rand_data = words[i];
         chk("pf_ready", 32'(rand_ready), 1);
         step();
      end
      rand_data = 9'h080;
      chk("pf_level", 32'(fifo_level), 4);
      chk("pf_full_ready", 32'(rand_ready), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pf_hold_level", 32'(fifo_level), 4);
      end

      // Countdown of 9'h183 (gap 102, bird) at speed 4.
      speed = 3'd4;
      run = 1'b1;
      step();
      chk("idle_to_load_level", 32'(fifo_level), 4);
      step();
      chk("after_pop_level", 32'(fifo_level), 3);
      chk("after_pop_ready", 32'(rand_ready), 1);
      step();
      rand_valid = 1'b0;
      chk("fifth_word_level", 32'(fifo_level), 4);
      expect_spawn(OBS_BIRD);
      run_until_spawn(40, n);
      chk("gap102_ticks", n, 26);

      // Word 9'h00D (gap 122): pause after 18 ticks, gap 50 left.
      step();
      for (int i = 0; i < 18; i++) begin
         tick = 1'b1; step(); tick = 1'b0; step();
      end
      run = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         tick = 1'b1; step(); tick = 1'b0; step();
      end
      chk("pause_starved", 32'(starved), 0);
      chk("pause_level", 32'(fifo_level), 3);
      run = 1'b1;
      step();
      step();
      chk("resume_pop_level", 32'(fifo_level), 2);
      expect_spawn(OBS_GROUP);
      run_until_spawn(40, n);
      chk("resume_fresh_ticks", n, 24);

      // Word 9'h07F (gap 350): speed 0 freezes, then speed 7.
      step();
      speed = 3'd0;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick = 1'b1; step();
         if (spawn) cnt++;
         tick = 1'b0; step();
      end
      chk("speed0_nospawn", cnt, 0);
      speed = 3'd7;
      expect_spawn(OBS_SMALL);
      run_until_spawn(80, n);
      chk("gap350_ticks", n, 50);

      // Word 9'h080 (gap 96, large) at speed 7.
      step();
      expect_spawn(OBS_LARGE);
      run_until_spawn(40, n);
      chk("gap96_s7_ticks", n, 14);

      // FIFO now empty: LOAD starves until a word arrives.
      chk("starve_state", 32'(starved), 1);
      step();
      chk("starve_hold", 32'(starved), 1);
      chk("starve_level", 32'(fifo_level), 0);
      rand_valid = 1'b1;
      rand_data = 9'h000;
      step();
      rand_valid = 1'b0;
      chk("starve_push_level", 32'(fifo_level), 1);
      step();
      chk("starve_clear", 32'(starved), 0);
      chk("starve_pop_level", 32'(fifo_level), 0);
      speed = 3'd4;
      expect_spawn(OBS_SMALL);
      run_until_spawn(40, n);
      chk("gap96_s4_ticks", n, 24);

      // Asynchronous reset mid-count.
      rand_valid = 1'b1;
      rand_data = 9'h001;
      step();
      rand_data = 9'h002;
      step();
      rand_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1; step(); tick = 1'b0; step();
      end
      chk("pre_rst_count", 32'(spawn_count), 5);
      chk("pre_rst_level", 32'(fifo_level), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(spawn_count), 0);
      chk("mid_rst_level", 32'(fifo_level), 0);
      chk("mid_rst_ready", 32'(rand_ready), 1);
      chk("mid_rst_starved", 32'(starved), 0);
      chk("mid_rst_spawn", 32'(spawn), 0);
      run = 1'b0;
      tick = 1'b0;
      exp_cnt = 8'd0;
      step();
      rst_n = 1'b1;
      step();

      // 256 back-to-back spawns: the counter wraps to 0.
      for (int i = 0; i < 256; i++) expect_spawn(OBS_SMALL);
      rand_valid = 1'b1;
      rand_data = 9'h000;
      speed = 3'd7;
      tick = 1'b1;
      run = 1'b1;
      cnt = 0;
      while (sb.size() != 0 && cnt < 20000) begin
         step();
         cnt++;
      end
      run = 1'b0;
      tick = 1'b0;
      rand_valid = 1'b0;
      if (cnt >= 20000) chk("wrap_timeout", 0, 1);
      step();
      step();
      chk("wrap_count", 32'(spawn_count), 0);
      chk("wrap_spawn_idle", 32'(spawn), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
